// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, mode constant and default sizing
// used by initiator- and responder-side blocks.
package spi_pkg;

   localparam int unsigned HALF_DEF   = 4;
   localparam int unsigned DATA_W_DEF = 8;

   // {CPOL, CPHA}
   localparam logic [1:0] SPI_MODE0 = 2'b00;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      HIGH,
      LOW,
      GAP
   } spi_state_e;

endpackage

// File: rtl/spi_master_tx_if.sv
// Core-side byte handshake plus SPI pins of the mode-0 initiator.
interface spi_master_tx_if
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) ();

   logic              start;
   logic [DATA_W-1:0] tx_data;
   logic              keep_ss;
   logic              ready;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              ss;
   logic              sclk;
   logic              mosi;
   logic              miso;

   // master: the SPI initiator itself
   modport master (
      input  start, tx_data, keep_ss, miso,
      output ready, rx_data, rx_valid, ss, sclk, mosi
   );

   // slave: the requesting core together with the attached responder
   modport slave (
      output start, tx_data, keep_ss, miso,
      input  ready, rx_data, rx_valid, ss, sclk, mosi
   );

endinterface

// File: rtl/spi_half_tick.sv
// Loadable down-counter giving a 1-cycle tick on the last clk of every HALF-cycle phase.
module spi_half_tick #(
   parameter int unsigned HALF = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic tick_c
);

   localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;

   logic [CW-1:0] cnt;

   // Reload on phase entry and on every tick so back-to-back phases need no extra load
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load || (cnt == '0)) begin
         cnt <= CW'(HALF - 1);
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tick_c = (cnt == '0);

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 initiator, MSB first, full-duplex DATA_W-bit transfers with optional
// ss hold between transfers for bursts.
module spi_master_tx
   import spi_pkg::*;
#(
   parameter int unsigned HALF   = HALF_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input logic             clk,
   input logic             rst,
   spi_master_tx_if.master bus
);

   localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   if (HALF < 2) begin : g_half_chk
      $error("spi_master_tx: HALF must be >= 2");
   end

   spi_state_e        state;
   logic [DATA_W-1:0] tx_sh;
   logic [DATA_W-1:0] rx_sh;
   logic [BW-1:0]     bit_cnt;
   logic              keep_q;
   logic              tail;
   logic              accept_c;
   logic              tick_c;

   assign accept_c = (state == IDLE) && bus.start && bus.ready;

   spi_half_tick #(.HALF(HALF)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .load   (accept_c),
      .tick_c (tick_c)
   );

   // tx_sh holds the bits still to be sent, MSB-aligned; mosi already carries the current one
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         bus.ss       <= 1'b1;
         bus.sclk     <= 1'b0;
         bus.mosi     <= 1'b0;
         bus.ready    <= 1'b1;
         bus.rx_valid <= 1'b0;
         bus.rx_data  <= '0;
         tx_sh        <= '0;
         rx_sh        <= '0;
         bit_cnt      <= '0;
         keep_q       <= 1'b0;
         tail         <= 1'b0;
      end else begin
         bus.rx_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept_c) begin
                  tx_sh     <= {bus.tx_data[DATA_W-2:0], 1'b0};
                  keep_q    <= bus.keep_ss;
                  bus.ready <= 1'b0;
                  bus.ss    <= 1'b0;
                  bus.mosi  <= bus.tx_data[DATA_W-1];
                  bit_cnt   <= BW'(DATA_W - 1);
                  tail      <= 1'b0;
                  state     <= LEAD;
               end else begin
                  bus.ready <= 1'b1;
               end
            end
            LEAD: begin
               if (tick_c) begin
                  bus.sclk <= 1'b1;
                  state    <= HIGH;
               end
            end
            HIGH: begin
               // Sample on the last high cycle, just before sclk falls
               if (tick_c) begin
                  rx_sh    <= {rx_sh[DATA_W-2:0], bus.miso};
                  bus.sclk <= 1'b0;
                  state    <= LOW;
                  if (bit_cnt == '0) begin
                     tail <= 1'b1;
                  end else begin
                     bit_cnt  <= bit_cnt - 1'b1;
                     bus.mosi <= tx_sh[DATA_W-1];
                     tx_sh    <= {tx_sh[DATA_W-2:0], 1'b0};
                  end
               end
            end
            LOW: begin
               if (tick_c) begin
                  if (tail) begin
                     tail         <= 1'b0;
                     bus.rx_valid <= 1'b1;
                     bus.rx_data  <= rx_sh;
                     if (keep_q) begin
                        state <= IDLE;
                     end else begin
                        bus.ss <= 1'b1;
                        state  <= GAP;
                     end
                  end else begin
                     bus.sclk <= 1'b1;
                     state    <= HIGH;
                  end
               end
            end
            GAP: begin
               if (tick_c) begin
                  bus.ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: HALF=2 and HALF=4 instances share stimulus,
// one is selected per transfer; table of transfers plus a mid-transfer reset sequence.
module tb_spi_master_tx;

   localparam int unsigned DW     = 8;
   localparam int          BUDGET = 400;
   localparam int          NVEC   = 7;

   typedef struct {
      logic       sel;           // 0: HALF=2 instance, 1: HALF=4 instance
      logic [7:0] tx;
      logic       keep;
      logic       loop;          // miso driven from mosi
      logic [7:0] resp;          // responder byte when not looped back
      logic       strict;        // responder drives the right bit only on the last high cycle
      logic       spam;          // hold start high and disturb tx/keep during the transfer
      logic [7:0] exp_rx;
      int         exp_ss_low;
      int         exp_ready_low;
      int         exp_mosi_ones;
      logic       exp_ss_pre;
      logic       exp_ss_valid;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          keep;
   logic          miso;
   logic          sel;
   logic [DW-1:0] tx;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   spi_master_tx_if #(.DATA_W(DW)) b2 ();
   spi_master_tx_if #(.DATA_W(DW)) b4 ();

   assign b2.start   = start & ~sel;
   assign b2.tx_data = tx;
   assign b2.keep_ss = keep;
   assign b2.miso    = miso;
   assign b4.start   = start & sel;
   assign b4.tx_data = tx;
   assign b4.keep_ss = keep;
   assign b4.miso    = miso;

   spi_master_tx #(.HALF(2), .DATA_W(DW)) dut2 (.clk(clk), .rst(rst), .bus(b2.master));
   spi_master_tx #(.HALF(4), .DATA_W(DW)) dut4 (.clk(clk), .rst(rst), .bus(b4.master));

   logic          ss_o, sclk_o, mosi_o, ready_o, valid_o;
   logic [DW-1:0] rx_o;

   assign ss_o    = sel ? b4.ss       : b2.ss;
   assign sclk_o  = sel ? b4.sclk     : b2.sclk;
   assign mosi_o  = sel ? b4.mosi     : b2.mosi;
   assign ready_o = sel ? b4.ready    : b2.ready;
   assign valid_o = sel ? b4.rx_valid : b2.rx_valid;
   assign rx_o    = sel ? b4.rx_data  : b2.rx_data;

   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of the first cycle with ready=1 again
   task automatic run_xfer(input vec_t v, input string tag);
      int         ss_low, rises, nvalid, ready_low, ones, hicnt, bitidx, h, n;
      logic [7:0] rx_got;
      logic       ss_valid, ss_pre, p_sclk, done, bit_c;
      h = v.sel ? 4 : 2;
      ss_low = 0; rises = 0; nvalid = 0; ready_low = 0; ones = 0; hicnt = 0; bitidx = 0;
      rx_got = 'x; ss_valid = 1'bx; p_sclk = 1'b0; done = 1'b0;
      sel = v.sel;
      #1;
      ss_pre = ss_o;
      check($sformatf("%s ready_pre", tag), 32'(ready_o), 32'd1);
      tx    = v.tx;
      keep  = v.keep;
      start = 1'b1;
      miso  = v.loop ? mosi_o : v.resp[7];
      @(posedge clk); #1;
      n = 1;
      if (v.spam) begin
         tx   = ~v.tx;
         keep = ~v.keep;
      end else begin
         start = 1'b0;
      end
      while (!done && n <= BUDGET) begin
         if (!ss_o) begin
            ss_low++;
            if (mosi_o) ones++;
         end
         if (sclk_o && !p_sclk) rises++;
         if (!sclk_o && p_sclk) bitidx++;
         hicnt = sclk_o ? hicnt + 1 : 0;
         if (valid_o) begin
            nvalid++;
            rx_got   = rx_o;
            ss_valid = ss_o;
         end
         if (ready_o) begin
            done  = 1'b1;
            start = 1'b0;
         end else begin
            ready_low++;
         end
         p_sclk = sclk_o;
         if (v.loop) begin
            miso = mosi_o;
         end else begin
            bit_c = (bitidx < 8) ? v.resp[7-bitidx] : 1'b0;
            miso  = (v.strict && !(sclk_o && hicnt == h)) ? ~bit_c : bit_c;
         end
         if (!done) begin
            @(posedge clk); #1;
            n++;
         end
      end
      check($sformatf("%s done_in_budget", tag), 32'(done), 32'd1);
      check($sformatf("%s ss_pre", tag), 32'(ss_pre), 32'(v.exp_ss_pre));
      check($sformatf("%s ss_low_cycles", tag), 32'(ss_low), 32'(v.exp_ss_low));
      check($sformatf("%s sclk_rises", tag), 32'(rises), 32'd8);
      check($sformatf("%s rx_valid_count", tag), 32'(nvalid), 32'd1);
      check($sformatf("%s rx_data_strobe", tag), 32'(rx_got), 32'(v.exp_rx));
      check($sformatf("%s rx_data_hold", tag), 32'(rx_o), 32'(v.exp_rx));
      check($sformatf("%s ss_at_valid", tag), 32'(ss_valid), 32'(v.exp_ss_valid));
      check($sformatf("%s ready_low_cycles", tag), 32'(ready_low), 32'(v.exp_ready_low));
      check($sformatf("%s mosi_ones", tag), 32'(ones), 32'(v.exp_mosi_ones));
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int   r, nv;
      logic p;
      vec_t v5a;

      // sel tx keep loop resp strict spam | rx ss_low ready_low mosi_ones ss_pre ss_valid
      vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, 34, 36, 18, 1'b1, 1'b1};
      vecs[1] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C, 68, 72,  0, 1'b1, 1'b1};
      vecs[2] = '{1'b0, 8'h81, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h81, 34, 36, 10, 1'b1, 1'b1};
      vecs[3] = '{1'b0, 8'h12, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h12, 36, 35,  8, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 8'h34, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h34, 34, 36, 12, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 8'hC3, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0, 8'h96, 34, 36, 18, 1'b1, 1'b1};
      vecs[6] = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, 68, 72, 36, 1'b1, 1'b1};
      v5a     = '{1'b0, 8'h5A, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h5A, 34, 36, 16, 1'b1, 1'b1};

      rst = 1'b0; start = 1'b0; keep = 1'b0; miso = 1'b0; sel = 1'b0; tx = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset ss", 32'(b2.ss), 32'd1);
      check("reset sclk", 32'(b2.sclk), 32'd0);
      check("reset mosi", 32'(b2.mosi), 32'd0);
      check("reset ready", 32'(b2.ready), 32'd1);
      check("reset rx_valid", 32'(b2.rx_valid), 32'd0);
      check("reset rx_data", 32'(b2.rx_data), 32'd0);
      check("reset ready_h4", 32'(b4.ready), 32'd1);
      #2 rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < NVEC; i++) begin
         run_xfer(vecs[i], $sformatf("v%0d", i));
      end

      // Abort a 0xFF transfer after its third rising sclk edge
      sel = 1'b0; #1;
      tx = 8'hFF; keep = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      r = 0; p = 1'b0; nv = 0;
      for (int k = 0; k < 100 && r < 3; k++) begin
         if (sclk_o && !p) r++;
         if (valid_o) nv++;
         p    = sclk_o;
         miso = mosi_o;
         if (r < 3) begin
            @(posedge clk); #1;
         end
      end
      check("abort sclk_rises", 32'(r), 32'd3);
      #2 rst = 1'b0;
      #1;
      check("abort ss", 32'(ss_o), 32'd1);
      check("abort sclk", 32'(sclk_o), 32'd0);
      check("abort ready", 32'(ready_o), 32'd1);
      check("abort rx_valid", 32'(valid_o), 32'd0);
      check("abort rx_data", 32'(rx_o), 32'd0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      repeat (40) begin
         @(posedge clk); #1;
         if (valid_o) nv++;
      end
      check("abort no_rx_valid", 32'(nv), 32'd0);
      check("abort idle_ready", 32'(ready_o), 32'd1);
      run_xfer(v5a, "post_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- SPI mode-0 initiator (CPOL=0, CPHA=0), MSB first, full-duplex byte transfers.
- Drives ss/sclk/mosi and samples miso of the sbasu3_top SPI responder.
- Sits in bench/host-side logic or a future top that configures sbasu3_top over SPI.
- Core-side byte interface uses a valid/ready request and a 1-cycle receive strobe.

Parameters:
- HALF, default 4: clk cycles per sclk half-period; legal range >= 2; HALF < 2 is an elaboration error.
- DATA_W, default 8: bits per transfer.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  transfer request; accepted when start & ready.
- tx_data  in  DATA_W  byte to send; latched on accept.
- keep_ss  in  1  latched on accept; 1 = hold ss low after this transfer (burst).
- ready  out  1  core can accept start.
- rx_data  out  DATA_W  last received byte; holds until next completion.
- rx_valid  out  1  1-cycle strobe, rx_data updated.
- ss  out  1  slave select, active-low.
- sclk  out  1  SPI clock.
- mosi  out  1  serial out.
- miso  in  1  serial in.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; ss=1, sclk=0, mosi=0, ready=1, rx_valid=0, rx_data=0.
  - Divider and bit counter cleared.
  - Mid-transfer reset aborts the transfer immediately; no rx_valid is issued.
- States: IDLE, LEAD, HIGH, LOW, GAP. One divider counts HALF cycles per phase; a bit counter counts DATA_W-1 down to 0.
- IDLE:
  - ready=1.
  - On start accept at cycle T: latch tx_data into shift reg and keep_ss; ready=0 from T+1.
  - ss=0 and mosi=tx_data[MSB] from T+1; go to LEAD.
- LEAD: sclk=0 for HALF cycles, then HIGH.
- HIGH:
  - sclk=1 for HALF cycles.
  - miso is sampled on the last clk of HIGH, the cycle before sclk falls, and shifted into the rx shift reg LSB.
- LOW (bits 1..DATA_W-1):
  - Entered with sclk=0 and mosi updated to the next bit in the same cycle.
  - Lasts HALF cycles, then HIGH.
- After the last HIGH: sclk=0, mosi unchanged, HALF trailing cycles.
- Then the completion cycle C:
  - rx_valid=1 for one cycle; rx_data = assembled byte.
  - If latched keep_ss=0: ss=1 at C and go to GAP.
  - If latched keep_ss=1: ss stays 0; ready=1 at C+1; state IDLE.
- GAP: ss=1, sclk=0 for HALF cycles, then IDLE with ready=1.
- Timing for keep_ss=0:
  - ss low for exactly (2*DATA_W+1)*HALF cycles.
  - DATA_W rising sclk edges.
  - ready=0 for (2*DATA_W+2)*HALF cycles after accept.
- Burst (keep_ss=1): the next start while ss is low re-enters LEAD without raising ss.
- Between transfers: IDLE with keep_ss burst open holds ss=0 indefinitely; only a keep_ss=0 transfer or reset releases it.
- Ignored input: start while ready=0 is dropped, with no queueing and no effect on the current transfer.
- Input stability: tx_data and keep_ss changes after accept have no effect.
- miso: sampled raw; the responder guarantees stability for the HALF >= 2 window. No synchronizer is in this block.
- sclk, ss, mosi are registered outputs, with no combinational path from inputs.

Decomposition:
- Shared package spi_pkg:
  - state enum (IDLE, LEAD, HIGH, LOW, GAP);
  - SPI_MODE0 constant;
  - default HALF and DATA_W localparams, shared with future responder-side blocks.
- One natural sub-module: spi_half_tick.
  - Loadable down-counter producing a 1-cycle tick every HALF clks.
  - Restarts on each phase entry.

Test Plan:
- HALF=2, tx_data=0xA5, miso tied to mosi (loopback):
  - rx_valid once, rx_data=0xA5;
  - ss low exactly 34 cycles;
  - 8 sclk rising edges;
  - ready high again 36 cycles after accept.
- HALF=4, tx_data=0x00, bench responder model returns 0x3C:
  - rx_data=0x3C;
  - mosi constant 0;
  - bits sampled on the cycle before each sclk fall.
- start pulsed every cycle during a transfer of 0x81:
  - only the first accepted;
  - exactly one rx_valid;
  - the next transfer starts only after ready=1.
- Burst 0x12 (keep_ss=1) then 0x34 (keep_ss=0), loopback:
  - ss never rises between bytes;
  - two rx_valid strobes with 0x12 then 0x34;
  - ss rises at the second completion.
- rst driven low after 3 sclk edges of 0xFF:
  - ss=1, sclk=0, ready=1 immediately without a clk edge;
  - no rx_valid;
  - the next transfer of 0x5A completes correctly.
